cl_rle_encoder: RTL
===================

CL_RLE_ENCODER -- requirements
Module: cl_rle_encoder

Interface
REQ-001 Parameters: none; all widths fixed by this document.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to encode; sampled only in IDLE.
REQ-005 hlit  in  9  number of literal/length code lengths, legal 257..286; sampled with start.
REQ-006 hdist  in  5  number of distance code lengths, legal 1..30; sampled with start.
REQ-007 cl_rd_sel  out  1  0 = literal/length length memory, 1 = distance length memory.
REQ-008 cl_rd_addr  out  9  read address within the selected memory.
REQ-009 cl_rd_en  out  1  read strobe; cl_rd_data is valid exactly 1 cycle after cl_rd_en.
REQ-010 cl_rd_data  in  4  code length 0..15.
REQ-011 sym_valid  out  1  output symbol valid.
REQ-012 sym_ready  in  1  consumer accepts symbol when sym_valid & sym_ready.
REQ-013 sym  out  5  code-length alphabet symbol 0..18.
REQ-014 sym_extra  out  7  extra-bit value; 0 for symbols 0..15.
REQ-015 sym_extra_len  out  3  extra-bit count: 0 for 0..15, 2 for 16, 3 for 17, 7 for 18.
REQ-016 busy  out  1  high from the cycle after accepted start until the cycle done pulses.
REQ-017 done  out  1  one-cycle pulse after the last symbol is accepted.
REQ-018 err  out  1  one-cycle pulse when start carries illegal hlit or hdist.
REQ-019 sym_count  out  9  symbols accepted in the current/last job; cleared on accepted start.

Function
REQ-020 Input sequence is ll[0..hlit-1] followed by dist[0..hdist-1], treated as one sequence of N = hlit+hdist entries; runs cross the ll/dist boundary.
REQ-021 Index i < hlit reads cl_rd_sel=0, addr=i; otherwise cl_rd_sel=1, addr=i-hlit.
REQ-022 FSM states: IDLE, FETCH, SCAN, EMIT, FINISH; start in IDLE with legal fields -> FETCH; illegal fields -> err, remain IDLE.
REQ-023 SCAN: maximal run (value v, length n, 1..316, 9-bit counter) accumulates while next entry equals v and index < N; differing entry or end -> EMIT, differing value retained as next run seed.
REQ-024 EMIT, v = 0: while n >= 11 emit 18 with extra min(n,138)-11 and subtract min(n,138); then 3..10 -> one 17 with extra n-3; 1..2 -> that many literal 0.
REQ-025 EMIT, v != 0: emit literal v once, m = n-1; while m >= 3 emit 16 with extra min(m,6)-3, subtract min(m,6); remaining 1..2 -> that many literal v.
REQ-026 Chunking is greedy in exactly the order above; no other splitting permitted.
REQ-027 sym, sym_extra, sym_extra_len held stable while sym_valid & !sym_ready; sym_valid never deasserts without acceptance.
REQ-028 At most one symbol accepted per cycle; back-to-back acceptance with sym_ready high sustains one symbol per cycle within a run.
REQ-029 After last run fully accepted -> FINISH: done=1 one cycle, busy=0, return IDLE; sym_count holds final value until next accepted start.
REQ-030 start while busy ignored; no reads issued outside FETCH/SCAN; no read of index >= N.
REQ-031 sym_count increments once per accepted symbol, saturates at 511.

Reset
REQ-032 reset in any state -> IDLE next cycle; sym_valid, busy, done, err, cl_rd_en, sym, sym_extra, sym_extra_len, cl_rd_sel, cl_rd_addr, sym_count all 0.
REQ-033 Reset mid-job abandons the job: no done, no further symbols, no reads.
REQ-034 Reset dominates start in the same cycle.

Verification
REQ-035 hlit=257, hdist=1, all 258 lengths 0, sym_ready=1 -> 18/127, 18/109; done; sym_count=2.
REQ-036 hlit=257, hdist=1, ll[0..6]=5, rest 0 -> 5, 16/3, 18/127, 18/102; sym_count=4.
REQ-037 hlit=257, hdist=3, ll[0..255]=0, ll[256]=7, dist[0..2]=7 -> 18/127, 18/107, 7, 16/0; boundary-crossing run encoded as one run.
REQ-038 Scenario REQ-036 with sym_ready low 5 cycles while 16/3 is presented -> sym=16, sym_extra=3, sym_extra_len=2 stable all 5 cycles; identical final sequence.
REQ-039 Reset asserted during EMIT of REQ-035 -> next cycle all outputs 0, no done; fresh start then reproduces REQ-035 exactly.
REQ-040 start with hlit=256 or hdist=0 -> err one cycle, busy stays 0, no cl_rd_en, no symbols.

Source files
------------

// File: rtl/cl_rle_encoder.sv
// Run-length encodes the concatenated literal/length and distance code-length
// sequences into the code-length alphabet (symbols 0..18 with extra bits).
module cl_rle_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] hlit,
  input  logic [4:0] hdist,
  output logic       cl_rd_sel,
  output logic [8:0] cl_rd_addr,
  output logic       cl_rd_en,
  input  logic [3:0] cl_rd_data,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [4:0] sym,
  output logic [6:0] sym_extra,
  output logic [2:0] sym_extra_len,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [8:0] sym_count
);

  localparam int unsigned IdxW = 9;
  localparam int unsigned LenW = 4;
  localparam int unsigned SymW = 5;
  localparam int unsigned ExtW = 7;
  localparam int unsigned ElnW = 3;

  typedef enum logic [2:0] {IDLE, FETCH, SCAN, EMIT, FINISH} state_t;

  state_t            state_q, state_d;
  logic [IdxW-1:0]   hlit_q, hlit_d;
  logic [IdxW-1:0]   ntot_q, ntot_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [LenW-1:0]   rv_q, rv_d;
  logic [IdxW-1:0]   rn_q, rn_d;
  logic              rfirst_q, rfirst_d;
  logic [LenW-1:0]   seed_q, seed_d;
  logic              seed_vld_q, seed_vld_d;

  logic              cl_rd_sel_d, cl_rd_en_d, sym_valid_d, busy_d, done_d, err_d;
  logic [IdxW-1:0]   cl_rd_addr_d, sym_count_d;
  logic [SymW-1:0]   sym_d;
  logic [ExtW-1:0]   sym_extra_d;
  logic [ElnW-1:0]   sym_extra_len_d;

  logic [SymW-1:0]   ck_sym;
  logic [ExtW-1:0]   ck_extra;
  logic [ElnW-1:0]   ck_elen;
  logic [IdxW-1:0]   ck_take;
  logic              legal;
  logic              accept;
  logic              load;

  assign legal  = (hlit >= 9'd257) && (hlit <= 9'd286) && (hdist >= 5'd1) && (hdist <= 5'd30);
  assign accept = sym_valid & sym_ready;

  // Next greedy chunk of the remaining run (rn_q entries of value rv_q).
  always_comb begin
    ck_sym   = SymW'(rv_q);
    ck_extra = '0;
    ck_elen  = '0;
    ck_take  = IdxW'(1);
    if (rv_q == '0) begin
      if (rn_q >= 9'd11) begin
        ck_take  = (rn_q > 9'd138) ? 9'd138 : rn_q;
        ck_sym   = 5'd18;
        ck_extra = ExtW'(ck_take - 9'd11);
        ck_elen  = 3'd7;
      end else if (rn_q >= 9'd3) begin
        ck_take  = rn_q;
        ck_sym   = 5'd17;
        ck_extra = ExtW'(rn_q - 9'd3);
        ck_elen  = 3'd3;
      end
    end else if (!rfirst_q && (rn_q >= 9'd3)) begin
      ck_take  = (rn_q > 9'd6) ? 9'd6 : rn_q;
      ck_sym   = 5'd16;
      ck_extra = ExtW'(ck_take - 9'd3);
      ck_elen  = 3'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    hlit_d          = hlit_q;
    ntot_d          = ntot_q;
    idx_d           = idx_q;
    rv_d            = rv_q;
    rn_d            = rn_q;
    rfirst_d        = rfirst_q;
    seed_d          = seed_q;
    seed_vld_d      = seed_vld_q;
    sym_valid_d     = sym_valid;
    sym_d           = sym;
    sym_extra_d     = sym_extra;
    sym_extra_len_d = sym_extra_len;
    sym_count_d     = sym_count;
    cl_rd_sel_d     = cl_rd_sel;
    cl_rd_addr_d    = cl_rd_addr;
    cl_rd_en_d      = 1'b0;
    err_d           = 1'b0;
    load            = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            hlit_d      = hlit;
            ntot_d      = hlit + IdxW'(hdist);
            idx_d       = '0;
            rn_d        = '0;
            seed_vld_d  = 1'b0;
            sym_count_d = '0;
            state_d     = FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: state_d = SCAN;
      SCAN: begin
        idx_d = idx_q + 9'd1;
        if ((rn_q == '0) || (cl_rd_data == rv_q)) begin
          if (rn_q == '0) begin
            rv_d     = cl_rd_data;
            rn_d     = 9'd1;
            rfirst_d = 1'b1;
          end else begin
            rn_d = rn_q + 9'd1;
          end
          state_d = ((idx_q + 9'd1) < ntot_q) ? FETCH : EMIT;
        end else begin
          // Differing entry closes the run and seeds the next one.
          seed_d     = cl_rd_data;
          seed_vld_d = 1'b1;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        load = !sym_valid || (accept && (rn_q != '0));
        if (accept && (sym_count != 9'h1FF)) sym_count_d = sym_count + 9'd1;
        if (load) begin
          sym_valid_d     = 1'b1;
          sym_d           = ck_sym;
          sym_extra_d     = ck_extra;
          sym_extra_len_d = ck_elen;
          rn_d            = rn_q - ck_take;
          rfirst_d        = 1'b0;
        end else if (accept) begin
          sym_valid_d = 1'b0;
          if (seed_vld_q) begin
            rv_d       = seed_q;
            rn_d       = 9'd1;
            rfirst_d   = 1'b1;
            seed_vld_d = 1'b0;
            state_d    = (idx_q < ntot_q) ? FETCH : EMIT;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == FETCH) begin
      cl_rd_en_d   = 1'b1;
      cl_rd_sel_d  = (idx_d >= hlit_d);
      cl_rd_addr_d = (idx_d >= hlit_d) ? (idx_d - hlit_d) : idx_d;
    end
    busy_d = (state_d == FETCH) || (state_d == SCAN) || (state_d == EMIT);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hlit_q        <= '0;
      ntot_q        <= '0;
      idx_q         <= '0;
      rv_q          <= '0;
      rn_q          <= '0;
      rfirst_q      <= 1'b0;
      seed_q        <= '0;
      seed_vld_q    <= 1'b0;
      cl_rd_sel     <= 1'b0;
      cl_rd_addr    <= '0;
      cl_rd_en      <= 1'b0;
      sym_valid     <= 1'b0;
      sym           <= '0;
      sym_extra     <= '0;
      sym_extra_len <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      sym_count     <= '0;
    end else begin
      hlit_q        <= hlit_d;
      ntot_q        <= ntot_d;
      idx_q         <= idx_d;
      rv_q          <= rv_d;
      rn_q          <= rn_d;
      rfirst_q      <= rfirst_d;
      seed_q        <= seed_d;
      seed_vld_q    <= seed_vld_d;
      cl_rd_sel     <= cl_rd_sel_d;
      cl_rd_addr    <= cl_rd_addr_d;
      cl_rd_en      <= cl_rd_en_d;
      sym_valid     <= sym_valid_d;
      sym           <= sym_d;
      sym_extra     <= sym_extra_d;
      sym_extra_len <= sym_extra_len_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
      sym_count     <= sym_count_d;
    end
  end

endmodule
